// File: rtl/rtc_24bit_counter.sv
// Stopwatch time base: six cascaded BCD digits (MM:SS:hh) advanced by a 100 Hz clock, with lap hold.
// Optional registered wrap pulse o_rollover when RTC_ROLLOVER_FLAG_EN is defined.
module rtc_24bit_counter (
    input  logic        i_rtcclk,
    input  logic        i_reset_n,
    input  logic        i_countenb,
    input  logic        i_countinit,
    input  logic        i_latchcount,
    output logic [23:0] o_count
`ifdef RTC_ROLLOVER_FLAG_EN
    ,
    output logic        o_rollover
`endif
);

    // Per-digit maximum, packed in the same nibble order as the count.
    localparam logic [23:0] DIGIT_MAX = 24'h595999;

    logic [23:0] count_q;
    logic [23:0] count_nxt;
    logic [23:0] hold_q;
    logic [5:0]  en;

    // Whole carry chain settles in one cycle, so a full wrap happens on a single edge.
    always_comb begin
        en        = '0;
        count_nxt = count_q;
        en[0]     = i_countenb;
        for (int k = 1; k < 6; k++) begin
            en[k] = en[k-1] && (count_q[4*(k-1) +: 4] == DIGIT_MAX[4*(k-1) +: 4]);
        end
        for (int k = 0; k < 6; k++) begin
            if (en[k]) begin
                if (count_q[4*k +: 4] >= DIGIT_MAX[4*k +: 4]) begin
                    count_nxt[4*k +: 4] = 4'd0;
                end else begin
                    count_nxt[4*k +: 4] = count_q[4*k +: 4] + 4'd1;
                end
            end
        end
        if (i_countinit) begin
            count_nxt = '0;
        end
    end

    // Hold captures the post-edge value, so dropping i_latchcount freezes exactly what was shown.
    always_ff @(posedge i_rtcclk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            count_q <= '0;
            hold_q  <= '0;
        end else begin
            count_q <= count_nxt;
            if (i_countinit) begin
                hold_q <= '0;
            end else if (i_latchcount) begin
                hold_q <= count_nxt;
            end
        end
    end

    assign o_count = i_latchcount ? count_q : hold_q;

`ifdef RTC_ROLLOVER_FLAG_EN
    logic wrap;

    assign wrap = en[5] && (count_q[23:20] == DIGIT_MAX[23:20]);

    always_ff @(posedge i_rtcclk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            o_rollover <= 1'b0;
        end else begin
            o_rollover <= wrap && !i_countinit;
        end
    end
`endif

endmodule

// File: tb/tb_rtc_24bit_counter.sv
// Directed self-checking bench for rtc_24bit_counter.
`timescale 1ns/1ps
module tb_rtc_24bit_counter;

    logic        clk;
    logic        rst_n;
    logic        countenb;
    logic        countinit;
    logic        latchcount;
    logic [23:0] count;
`ifdef RTC_ROLLOVER_FLAG_EN
    logic        rollover;
`endif

    int checks   = 0;
    int failures = 0;

    rtc_24bit_counter dut (
        .i_rtcclk     (clk),
        .i_reset_n    (rst_n),
        .i_countenb   (countenb),
        .i_countinit  (countinit),
        .i_latchcount (latchcount),
        .o_count      (count)
`ifdef RTC_ROLLOVER_FLAG_EN
        ,
        .o_rollover   (rollover)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_count();
        countinit = 1'b1;
        tick();
        countinit = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; countenb = 1'b0; countinit = 1'b0; latchcount = 1'b0;
        #12;
        checks++;
        if (count !== 24'h000000) begin
            failures++; $display("FAIL reset_hold got=%h exp=000000", count);
        end
        latchcount = 1'b1;
        #1;
        checks++;
        if (count !== 24'h000000) begin
            failures++; $display("FAIL reset_live got=%h exp=000000", count);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_units_carry();
        countenb = 1'b1; latchcount = 1'b1;
        for (int i = 1; i <= 9; i++) begin
            tick();
            checks++;
            if (count !== 24'(i)) begin
                failures++; $display("FAIL units_count step=%0d got=%h exp=%h", i, count, 24'(i));
            end
        end
        tick();
        checks++;
        if (count !== 24'h000010) begin
            failures++; $display("FAIL units_carry got=%h exp=000010", count);
        end
    endtask

    task automatic test_wait_five();
        int n;
        clear_count();
        checks++;
        if (count !== 24'h000000) begin
            failures++; $display("FAIL init_clear got=%h exp=000000", count);
        end
        n = 0;
        while (count !== 24'h000005 && n < 20) begin
            tick(); n++;
        end
        checks++;
        if (count !== 24'h000005) begin
            failures++; $display("FAIL wait_five timeout got=%h exp=000005", count);
        end
        tick();
        checks++;
        if (count !== 24'h000006) begin
            failures++; $display("FAIL five_to_six got=%h exp=000006", count);
        end
    endtask

    task automatic test_minute_carry();
        int n;
        clear_count();
        n = 0;
        while (count !== 24'h005999 && n < 7000) begin
            tick(); n++;
        end
        checks++;
        if (n !== 5999) begin
            failures++; $display("FAIL minute_cycles got=%0d exp=5999", n);
        end
        tick();
        checks++;
        if (count !== 24'h010000) begin
            failures++; $display("FAIL minute_carry got=%h exp=010000", count);
        end
    endtask

    task automatic test_wrap();
        countenb = 1'b0;
        force dut.count_q = 24'h595998;
        #1;
        release dut.count_q;
        #1;
        checks++;
        if (count !== 24'h595998) begin
            failures++; $display("FAIL wrap_preload got=%h exp=595998", count);
        end
        countenb = 1'b1;
        tick();
        checks++;
        if (count !== 24'h595999) begin
            failures++; $display("FAIL wrap_max got=%h exp=595999", count);
        end
`ifdef RTC_ROLLOVER_FLAG_EN
        checks++;
        if (rollover !== 1'b0) begin
            failures++; $display("FAIL rollover_early got=%b exp=0", rollover);
        end
`endif
        tick();
        checks++;
        if (count !== 24'h000000) begin
            failures++; $display("FAIL wrap_zero got=%h exp=000000", count);
        end
`ifdef RTC_ROLLOVER_FLAG_EN
        checks++;
        if (rollover !== 1'b1) begin
            failures++; $display("FAIL rollover_pulse got=%b exp=1", rollover);
        end
`endif
        tick();
        checks++;
        if (count !== 24'h000001) begin
            failures++; $display("FAIL wrap_resume got=%h exp=000001", count);
        end
`ifdef RTC_ROLLOVER_FLAG_EN
        checks++;
        if (rollover !== 1'b0) begin
            failures++; $display("FAIL rollover_width got=%b exp=0", rollover);
        end
`endif
        countenb = 1'b0;
        force dut.count_q = 24'h095999;
        #1;
        release dut.count_q;
        countenb = 1'b1;
        tick();
        checks++;
        if (count !== 24'h100000) begin
            failures++; $display("FAIL tens_minute got=%h exp=100000", count);
        end
        countenb = 1'b0;
        force dut.count_q = 24'h195959;
        #1;
        release dut.count_q;
        countenb = 1'b1;
        tick();
        checks++;
        if (count !== 24'h195960) begin
            failures++; $display("FAIL hundredths_59 got=%h exp=195960", count);
        end
    endtask

    task automatic test_async_reset();
        clear_count();
        repeat (5) tick();
        checks++;
        if (count !== 24'h000005) begin
            failures++; $display("FAIL pre_reset got=%h exp=000005", count);
        end
        rst_n = 1'b0;
        #3;
        checks++;
        if (count !== 24'h000000) begin
            failures++; $display("FAIL async_reset got=%h exp=000000", count);
        end
        rst_n = 1'b1;
        tick();
        checks++;
        if (count !== 24'h000001) begin
            failures++; $display("FAIL post_reset got=%h exp=000001", count);
        end
    endtask

    task automatic test_lap_hold();
        clear_count();
        repeat (12) tick();
        checks++;
        if (count !== 24'h000012) begin
            failures++; $display("FAIL lap_reach got=%h exp=000012", count);
        end
        latchcount = 1'b0;
        #1;
        checks++;
        if (count !== 24'h000012) begin
            failures++; $display("FAIL lap_freeze got=%h exp=000012", count);
        end
        for (int i = 0; i < 8; i++) begin
            tick();
            checks++;
            if (count !== 24'h000012) begin
                failures++; $display("FAIL lap_hold step=%0d got=%h exp=000012", i, count);
            end
        end
        latchcount = 1'b1;
        #1;
        checks++;
        if (count !== 24'h000020) begin
            failures++; $display("FAIL lap_live got=%h exp=000020", count);
        end
        countenb = 1'b0;
        repeat (3) tick();
        checks++;
        if (count !== 24'h000020) begin
            failures++; $display("FAIL enable_hold got=%h exp=000020", count);
        end
        countenb = 1'b1;
        countinit = 1'b1;
        tick();
        checks++;
        if (count !== 24'h000000) begin
            failures++; $display("FAIL init_over_enable got=%h exp=000000", count);
        end
        countinit = 1'b0;
        tick();
        checks++;
        if (count !== 24'h000001) begin
            failures++; $display("FAIL init_resume got=%h exp=000001", count);
        end
        repeat (4) tick();
        latchcount = 1'b0;
        #1;
        checks++;
        if (count !== 24'h000005) begin
            failures++; $display("FAIL hold_before_init got=%h exp=000005", count);
        end
        clear_count();
        checks++;
        if (count !== 24'h000000) begin
            failures++; $display("FAIL hold_init_clear got=%h exp=000000", count);
        end
        latchcount = 1'b1;
    endtask

    initial begin
        test_reset();
        test_units_carry();
        test_wait_five();
        test_minute_carry();
        test_wrap();
        test_async_reset();
        test_lap_hold();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

endmodule
